// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C/SCCB sensor register target:
//   - i2c_state_e : byte-level FSM states of the target
//   - I2C_ACK / I2C_NACK : SDA level of the acknowledge bit
//   - REG_STREAM / REG_SWRST : sub-addresses with side effects
// ---------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        DEV     = 4'd1,
        ACK_DEV = 4'd2,
        AH      = 4'd3,
        ACK_AH  = 4'd4,
        AL      = 4'd5,
        ACK_AL  = 4'd6,
        WR      = 4'd7,
        ACK_WR  = 4'd8,
        RD      = 4'd9,
        RD_ACK  = 4'd10
    } i2c_state_e;

    // SDA level seen on the 9th clock of a byte.
    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    // Registers with side effects beyond the register file.
    localparam logic [15:0] REG_STREAM = 16'h0100;
    localparam logic [15:0] REG_SWRST  = 16'h0103;

endpackage

// File: rtl/i2c_line_filter.sv
// ---------------------------------------------------------------------------
// i2c_line_filter
// Conditions one asynchronous I2C pad input: 2-flop synchronizer, then a
// glitch filter that accepts a new level only after FILT_LEN consecutive
// equal samples, then edge detection. A pad edge shows up on level/rise/fall
// 2+FILT_LEN clk later. The idle bus level is high, so everything resets to 1.
//
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-high reset
//   pin   in   raw pad input (asynchronous)
//   level out  filtered line level
//   rise  out  one-cycle pulse when level goes 0 -> 1
//   fall  out  one-cycle pulse when level goes 1 -> 0
// ---------------------------------------------------------------------------
module i2c_line_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            level  <= 1'b1;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pin};
            rise   <= 1'b0;
            fall   <= 1'b0;
            // cnt_q counts how many samples in a row have disagreed with the
            // accepted level; any agreeing sample restarts the count.
            if (sync_q[1] == level) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILT_LEN - 1)) begin
                cnt_q <= '0;
                level <= sync_q[1];
                rise  <= sync_q[1];
                fall  <= ~sync_q[1];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_sensor_reg_target.sv
// ---------------------------------------------------------------------------
// i2c_sensor_reg_target
// I2C/SCCB target with a 16-bit sub-address and 8-bit data, emulating the
// register interface of an image sensor. Writes land in an internal byte
// register file (indexed by the low MEM_AW sub-address bits) and are also
// reported on wr_stb/wr_addr/wr_data. Reads return register-file contents.
// Sub-address auto-increments after every data byte (modulo 2**16).
//
// Ports:
//   clk        in   system clock (>= 20x SCL)
//   rst        in   asynchronous active-high reset
//   scl_i      in   SCL pad input
//   sda_i      in   SDA pad input
//   sda_oe     out  1 = pull SDA low, 0 = release
//   wr_stb     out  one-cycle pulse per data byte written
//   wr_addr    out  full 16-bit sub-address of the written byte
//   wr_data    out  written byte
//   stream_on  out  bit0 of last byte written to REG_STREAM
//   soft_rst   out  one-cycle pulse when REG_SWRST is written with bit0 = 1
//   busy       out  high from START to STOP
//   state_dbg  out  current FSM state
//
// wr_stb is a pure strobe: wr_addr/wr_data are valid only in the cycle
// wr_stb is high, there is no ready/back-pressure, and every write produces
// exactly one pulse. soft_rst, when it fires, coincides with that pulse.
// ---------------------------------------------------------------------------
module i2c_sensor_reg_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h36,
    parameter int         MEM_AW   = 8,
    parameter int         FILT_LEN = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    output logic        wr_stb,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        stream_on,
    output logic        soft_rst,
    output logic        busy,
    output i2c_state_e  state_dbg
);

    // ---------------- input conditioning ----------------
    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk   (clk),
        .rst   (rst),
        .pin   (scl_i),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk   (clk),
        .rst   (rst),
        .pin   (sda_i),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    logic start_det;
    logic stop_det;
    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    // ---------------- state ----------------
    i2c_state_e  state_q;
    logic [3:0]  bit_cnt_q;
    logic [7:0]  rx_q;
    logic [7:0]  tx_q;
    logic [7:0]  ah_q;
    logic [15:0] sub_addr_q;
    logic        rw_q;
    // In ACK_* states: 0 = waiting for the fall that starts the ACK clock,
    // 1 = ACK is being driven. In RD_ACK: 1 = master acknowledged.
    logic        ack_ph_q;

    logic [7:0]  rx_byte;
    assign rx_byte = {rx_q[6:0], sda_lvl};

    // ---------------- register file ----------------
    // Not reset: contents survive rst, like the sensor's own registers.
    logic [7:0] mem [0:(1 << MEM_AW) - 1];
    logic [7:0] rd_byte;

    always_ff @(posedge clk) begin
        if (wr_stb) begin
            mem[wr_addr[MEM_AW-1:0]] <= wr_data;
        end
    end

    assign rd_byte   = mem[sub_addr_q[MEM_AW-1:0]];
    assign state_dbg = state_q;

    // ---------------- protocol FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd0;
            rx_q       <= 8'd0;
            tx_q       <= 8'd0;
            ah_q       <= 8'd0;
            sub_addr_q <= 16'd0;
            rw_q       <= 1'b0;
            ack_ph_q   <= 1'b0;
            sda_oe     <= 1'b0;
            wr_stb     <= 1'b0;
            wr_addr    <= 16'd0;
            wr_data    <= 8'd0;
            stream_on  <= 1'b0;
            soft_rst   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            wr_stb   <= 1'b0;
            soft_rst <= 1'b0;

            // STOP and START override whatever byte is in flight; a partial
            // byte is simply dropped because writes only happen on bit 8.
            if (stop_det) begin
                state_q <= IDLE;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else if (start_det) begin
                state_q   <= DEV;
                busy      <= 1'b1;
                sda_oe    <= 1'b0;
                bit_cnt_q <= 4'd0;
                ack_ph_q  <= 1'b0;
            end else begin
                case (state_q)
                    // Receive states: shift on SCL rise, act on the 8th bit.
                    DEV, AH, AL, WR: begin
                        if (scl_rise) begin
                            rx_q <= rx_byte;
                            if (bit_cnt_q == 4'd7) begin
                                bit_cnt_q <= 4'd0;
                                ack_ph_q  <= 1'b0;
                                case (state_q)
                                    DEV: begin
                                        if (rx_byte[7:1] == DEV_ADDR) begin
                                            rw_q    <= rx_byte[0];
                                            state_q <= ACK_DEV;
                                        end else begin
                                            state_q <= IDLE;
                                        end
                                    end
                                    AH: begin
                                        ah_q    <= rx_byte;
                                        state_q <= ACK_AH;
                                    end
                                    AL: begin
                                        sub_addr_q <= {ah_q, rx_byte};
                                        state_q    <= ACK_AL;
                                    end
                                    default: begin
                                        wr_stb     <= 1'b1;
                                        wr_addr    <= sub_addr_q;
                                        wr_data    <= rx_byte;
                                        sub_addr_q <= sub_addr_q + 16'd1;
                                        if (sub_addr_q == REG_STREAM) begin
                                            stream_on <= rx_byte[0];
                                        end
                                        soft_rst <= (sub_addr_q == REG_SWRST) && rx_byte[0];
                                        state_q  <= ACK_WR;
                                    end
                                endcase
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end

                    // Target ACK: drive low on the fall after bit 8,
                    // release on the fall after the 9th clock.
                    ACK_DEV, ACK_AH, ACK_AL, ACK_WR: begin
                        if (scl_fall) begin
                            if (!ack_ph_q) begin
                                sda_oe   <= 1'b1;
                                ack_ph_q <= 1'b1;
                            end else begin
                                ack_ph_q  <= 1'b0;
                                sda_oe    <= 1'b0;
                                bit_cnt_q <= 4'd0;
                                case (state_q)
                                    ACK_DEV: begin
                                        if (rw_q) begin
                                            // First read bit goes out on this same fall.
                                            state_q   <= RD;
                                            tx_q      <= rd_byte;
                                            sda_oe    <= ~rd_byte[7];
                                            bit_cnt_q <= 4'd1;
                                        end else begin
                                            state_q <= AH;
                                        end
                                    end
                                    ACK_AH:  state_q <= AL;
                                    default: state_q <= WR;
                                endcase
                            end
                        end
                    end

                    // Transmit: bit_cnt_q counts bits already placed on SDA.
                    RD: begin
                        if (scl_fall) begin
                            if (bit_cnt_q == 4'd8) begin
                                sda_oe   <= 1'b0;
                                ack_ph_q <= 1'b0;
                                state_q  <= RD_ACK;
                            end else begin
                                sda_oe    <= ~tx_q[6];
                                tx_q      <= {tx_q[6:0], 1'b0};
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end

                    RD_ACK: begin
                        if (scl_rise) begin
                            sub_addr_q <= sub_addr_q + 16'd1;
                            if (sda_lvl == I2C_NACK) begin
                                state_q <= IDLE;
                            end else begin
                                ack_ph_q <= 1'b1;
                            end
                        end else if (scl_fall && ack_ph_q) begin
                            ack_ph_q  <= 1'b0;
                            state_q   <= RD;
                            tx_q      <= rd_byte;
                            sda_oe    <= ~rd_byte[7];
                            bit_cnt_q <= 4'd1;
                        end
                    end

                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
